// File: rtl/morse_pkg.sv
// Shared Morse definitions: timer FSM states, symbol encoding used by the decoder, letter length cap.
package morse_pkg;

   typedef enum logic [2:0] {
      ARM   = 3'd0,
      IDLE  = 3'd1,
      PRESS = 3'd2,
      GAP   = 3'd3,
      WGAP  = 3'd4
   } state_t;

   localparam logic SYM_DOT  = 1'b1;
   localparam logic SYM_DASH = 1'b0;

   localparam logic [2:0] LEN_MAX = 3'd7;

   function automatic logic [2:0] len_inc(input logic [2:0] len);
      return (len == LEN_MAX) ? LEN_MAX : len + 3'd1;
   endfunction

endpackage

// File: rtl/morse_debounce.sv
// Key synchronizer plus stability filter; output follows the raw key after DEB_LEN stable cycles.
// Latency 2+DEB_LEN cycles; pulses shorter than DEB_LEN are dropped; no backpressure.
module morse_debounce #(
   parameter int DEB_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key_filt
);

   localparam int DW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
   localparam logic [DW-1:0] STABLE_LAST = DW'(DEB_LEN - 1);

   logic          sync1;
   logic          sync2;
   logic [DW-1:0] stab;

   always_ff @(posedge clk) begin
      sync1 <= key_raw;
      sync2 <= sync1;
      // Under reset the filter tracks the synchronized key, so a key held through reset stays seen as held.
      if (!reset) begin
         stab     <= '0;
         key_filt <= sync2;
      end else if (sync2 == key_filt) begin
         stab <= '0;
      end else if (stab == STABLE_LAST) begin
         key_filt <= sync2;
         stab     <= '0;
      end else begin
         stab <= stab + 1'b1;
      end
   end

endmodule

// File: rtl/morse_symbol_timer.sv
// Morse key timer: classifies presses as dot/dash, strobes letter and word ends; optional MORSE_DEBOUNCE_EN filter.
// Latency: release seen on sym_valid two edges later (plus 2+DEB_LEN with the filter); no backpressure.
module morse_symbol_timer
   import morse_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int DASH_MIN   = 6,
   parameter int LETTER_GAP = 12,
   parameter int WORD_GAP   = 28,
   parameter int DEB_LEN    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key,
   output logic       sym_valid,
   output logic       sym_bit,
   output logic       letter_end,
   output logic [2:0] letter_len,
   output logic       word_end
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DASH_T   = CNT_W'(DASH_MIN);
   localparam logic [CNT_W-1:0] LETTER_T = CNT_W'(LETTER_GAP);
   localparam logic [CNT_W-1:0] WORD_T   = CNT_W'(WORD_GAP);

   logic key_src;

`ifdef MORSE_DEBOUNCE_EN
   morse_debounce #(
      .DEB_LEN (DEB_LEN)
   ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .key_raw  (key),
      .key_filt (key_src)
   );
`else
   assign key_src = key;
`endif

   // key_q is deliberately not reset: a key held through reset must keep ARM waiting for release.
   logic key_q;

   always_ff @(posedge clk) begin
      key_q <= key_src;
   end

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + 1'b1;
   endfunction

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       len, len_n;
   logic             sym_valid_n;
   logic             sym_bit_n;
   logic             letter_end_n;
   logic [2:0]       letter_len_n;
   logic             word_end_n;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ARM;
         cnt        <= '0;
         len        <= '0;
         sym_valid  <= 1'b0;
         sym_bit    <= 1'b0;
         letter_end <= 1'b0;
         letter_len <= '0;
         word_end   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         len        <= len_n;
         sym_valid  <= sym_valid_n;
         sym_bit    <= sym_bit_n;
         letter_end <= letter_end_n;
         letter_len <= letter_len_n;
         word_end   <= word_end_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      len_n        = len;
      sym_valid_n  = 1'b0;
      sym_bit_n    = 1'b0;
      letter_end_n = 1'b0;
      letter_len_n = '0;
      word_end_n   = 1'b0;

      case (state)
         ARM: begin
            cnt_n = '0;
            len_n = '0;
            if (!key_q) begin
               state_n = IDLE;
            end
         end

         IDLE: begin
            if (key_q) begin
               state_n = PRESS;
               cnt_n   = CNT_ONE;
               len_n   = '0;
            end
         end

         PRESS: begin
            if (key_q) begin
               cnt_n = cnt_inc(cnt);
            end else begin
               sym_valid_n = 1'b1;
               sym_bit_n   = (cnt < DASH_T) ? SYM_DOT : SYM_DASH;
               len_n       = len_inc(len);
               cnt_n       = CNT_ONE;
               state_n     = GAP;
            end
         end

         // A new press has priority over a gap timeout landing on the same edge.
         GAP: begin
            if (key_q) begin
               state_n = PRESS;
               cnt_n   = CNT_ONE;
            end else begin
               cnt_n = cnt_inc(cnt);
               if (cnt == LETTER_T) begin
                  letter_end_n = 1'b1;
                  letter_len_n = len;
                  state_n      = WGAP;
               end
            end
         end

         WGAP: begin
            if (key_q) begin
               state_n = PRESS;
               cnt_n   = CNT_ONE;
               len_n   = '0;
            end else begin
               cnt_n = cnt_inc(cnt);
               if (cnt == WORD_T) begin
                  word_end_n = 1'b1;
                  state_n    = IDLE;
               end
            end
         end

         default: begin
            state_n = ARM;
         end
      endcase
   end

endmodule

// File: tb/tb_morse_symbol_timer.sv
// Bench for morse_symbol_timer: key run-length stimulus scored against a run-length event model.
module tb_morse_symbol_timer;

   localparam int DASH_MIN   = 6;
   localparam int LETTER_GAP = 12;
   localparam int WORD_GAP   = 28;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       key = 1'b0;
   logic       sym_valid;
   logic       sym_bit;
   logic       letter_end;
   logic [2:0] letter_len;
   logic       word_end;

   int total = 0;
   int bad   = 0;

   int         seg_q[$];   // alternating run lengths: high, low, high, low ...
   bit         kseq[$];    // key value per cycle
   logic [6:0] exp_ev[$];  // {sym_valid, sym_bit, letter_end, letter_len, word_end} per key sample
   logic [6:0] obs[$];

   morse_symbol_timer #(
      .CNT_W      (8),
      .DASH_MIN   (DASH_MIN),
      .LETTER_GAP (LETTER_GAP),
      .WORD_GAP   (WORD_GAP),
      .DEB_LEN    (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key        (key),
      .sym_valid  (sym_valid),
      .sym_bit    (sym_bit),
      .letter_end (letter_end),
      .letter_len (letter_len),
      .word_end   (word_end)
   );

   always #5 clk = ~clk;

   // sym_bit and letter_len only carry meaning alongside their strobes.
   function automatic logic [6:0] snap();
      return {sym_valid, sym_bit & sym_valid, letter_end, letter_len & {3{letter_end}}, word_end};
   endfunction

   // Reference: each press ends in one symbol; a silence longer than LETTER_GAP closes the
   // letter LETTER_GAP samples into it, longer than WORD_GAP closes the word likewise.
   task automatic build();
      int n, i, s, e, run_lo, sym_cnt;
      bit open;
      logic [6:0] v;
      kseq.delete();
      exp_ev.delete();
      foreach (seg_q[g])
         for (int r = 0; r < seg_q[g]; r++) kseq.push_back(g % 2 == 0);
      n = kseq.size();
      for (int t = 0; t < n; t++) exp_ev.push_back(7'd0);
      i = 0; sym_cnt = 0; open = 1'b0;
      while (i < n) begin
         if (!kseq[i]) begin
            i++;
         end else begin
            s = i;
            while (i < n && kseq[i]) i++;
            if (i < n) begin
               if (!open) sym_cnt = 0;
               open = 1'b1;
               if (sym_cnt < 7) sym_cnt++;
               v = exp_ev[i];
               v[6] = 1'b1;
               v[5] = (i - s < DASH_MIN);
               exp_ev[i] = v;
               e = i;
               while (i < n && !kseq[i]) i++;
               run_lo = i - e;
               if (run_lo > LETTER_GAP) begin
                  v = exp_ev[e + LETTER_GAP];
                  v[4] = 1'b1;
                  v[3:1] = 3'(sym_cnt);
                  exp_ev[e + LETTER_GAP] = v;
                  open = 1'b0;
               end
               if (run_lo > WORD_GAP) begin
                  v = exp_ev[e + WORD_GAP];
                  v[0] = 1'b1;
                  exp_ev[e + WORD_GAP] = v;
               end
            end
         end
      end
   endtask

   // Outputs caused by key sample n are visible at the second falling edge after it is driven.
   task automatic play();
      obs.delete();
      for (int n = 0; n < kseq.size() + 2; n++) begin
         @(negedge clk);
         if (n >= 2) obs.push_back(snap());
         key = (n < kseq.size()) ? kseq[n] : 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      key   = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (snap() !== 7'd0) begin
         bad++;
         $display("FAIL reset_state got=%b exp=%b", snap(), 7'd0);
      end
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (snap() !== 7'd0) begin
            bad++;
            $display("FAIL reset_quiet cyc=%0d got=%b exp=%b", c, snap(), 7'd0);
         end
      end
   endtask

   task automatic test_single_dot();
      int le_at, we_at, nsym;
      seg_q = {3, 40};
      build();
      play();
      le_at = -1; we_at = -1; nsym = 0;
      foreach (obs[j]) begin
         total++;
         if (obs[j] !== exp_ev[j]) begin
            bad++;
            $display("FAIL single_dot idx=%0d got=%b exp=%b", j, obs[j], exp_ev[j]);
         end
         if (obs[j][6]) nsym++;
         if (obs[j][4]) le_at = j;
         if (obs[j][0]) we_at = j;
      end
      total++;
      if (nsym !== 1) begin
         bad++;
         $display("FAIL single_dot_count got=%0d exp=1", nsym);
      end
      total++;
      if (le_at < 0 || we_at - le_at !== 16) begin
         bad++;
         $display("FAIL word_after_letter got=%0d exp=16", we_at - le_at);
      end
   endtask

   task automatic test_dot_dash();
      seg_q = {DASH_MIN - 1, 4, DASH_MIN, 40};
      build();
      play();
      foreach (obs[j]) begin
         total++;
         if (obs[j] !== exp_ev[j]) begin
            bad++;
            $display("FAIL dot_dash idx=%0d got=%b exp=%b", j, obs[j], exp_ev[j]);
         end
      end
   endtask

   task automatic test_letter_h();
      logic [2:0] got_len;
      seg_q = {2, 11, 2, 11, 2, 11, 2, 40};
      build();
      play();
      got_len = 3'd0;
      foreach (obs[j]) begin
         total++;
         if (obs[j] !== exp_ev[j]) begin
            bad++;
            $display("FAIL letter_h idx=%0d got=%b exp=%b", j, obs[j], exp_ev[j]);
         end
         if (obs[j][4]) got_len = obs[j][3:1];
      end
      total++;
      if (got_len !== 3'd4) begin
         bad++;
         $display("FAIL letter_h_len got=%0d exp=4", got_len);
      end
   endtask

   task automatic test_len_saturate();
      logic [2:0] got_len;
      seg_q.delete();
      for (int d = 0; d < 8; d++) begin
         seg_q.push_back(2);
         seg_q.push_back(d == 7 ? 40 : 3);
      end
      build();
      play();
      got_len = 3'd0;
      foreach (obs[j]) begin
         total++;
         if (obs[j] !== exp_ev[j]) begin
            bad++;
            $display("FAIL len_saturate idx=%0d got=%b exp=%b", j, obs[j], exp_ev[j]);
         end
         if (obs[j][4]) got_len = obs[j][3:1];
      end
      total++;
      if (got_len !== 3'd7) begin
         bad++;
         $display("FAIL len_saturate_len got=%0d exp=7", got_len);
      end
   endtask

   task automatic test_long_press();
      int nsym;
      seg_q = {300, 40};
      build();
      play();
      nsym = 0;
      foreach (obs[j]) begin
         total++;
         if (obs[j] !== exp_ev[j]) begin
            bad++;
            $display("FAIL long_press idx=%0d got=%b exp=%b", j, obs[j], exp_ev[j]);
         end
         if (obs[j][6] && !obs[j][5]) nsym++;
      end
      total++;
      if (nsym !== 1) begin
         bad++;
         $display("FAIL long_press_dashes got=%0d exp=1", nsym);
      end
   endtask

   task automatic test_gap_boundary();
      int gaps[4]   = '{12, 13, 28, 29};
      int exp_le[4] = '{1, 2, 2, 2};
      int exp_we[4] = '{1, 1, 1, 2};
      int nle, nwe;
      foreach (gaps[g]) begin
         seg_q = {2, gaps[g], 2, 40};
         build();
         play();
         nle = 0; nwe = 0;
         foreach (obs[j]) begin
            total++;
            if (obs[j] !== exp_ev[j]) begin
               bad++;
               $display("FAIL gap_%0d idx=%0d got=%b exp=%b", gaps[g], j, obs[j], exp_ev[j]);
            end
            if (obs[j][4]) nle++;
            if (obs[j][0]) nwe++;
         end
         total++;
         if (nle !== exp_le[g] || nwe !== exp_we[g]) begin
            bad++;
            $display("FAIL gap_%0d_counts got=%0d/%0d exp=%0d/%0d", gaps[g], nle, nwe, exp_le[g], exp_we[g]);
         end
      end
   endtask

   task automatic test_reset_mid();
      // Reset in the middle of a press, key still held afterwards: nothing may come out.
      @(negedge clk);
      key = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         total++;
         if (snap() !== 7'd0) begin
            bad++;
            $display("FAIL mid_press cyc=%0d got=%b exp=%b", c, snap(), 7'd0);
         end
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (c == 20) key = 1'b0;
         total++;
         if (snap() !== 7'd0) begin
            bad++;
            $display("FAIL held_through_reset cyc=%0d got=%b exp=%b", c, snap(), 7'd0);
         end
      end
      // Reset inside the gap of an open letter: its letter_end must never appear.
      seg_q = {3, 6};
      build();
      play();
      foreach (obs[j]) begin
         total++;
         if (obs[j] !== exp_ev[j]) begin
            bad++;
            $display("FAIL pre_gap_reset idx=%0d got=%b exp=%b", j, obs[j], exp_ev[j]);
         end
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         total++;
         if (snap() !== 7'd0) begin
            bad++;
            $display("FAIL mid_gap_reset cyc=%0d got=%b exp=%b", c, snap(), 7'd0);
         end
      end
   endtask

   task automatic test_random();
      int edge_lo[6] = '{11, 12, 13, 27, 28, 29};
      for (int round = 0; round < 6; round++) begin
         seg_q.delete();
         for (int p = 0; p < 10; p++) begin
            seg_q.push_back(($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 300))
                                                        : int'($urandom_range(1, 10)));
            if (p == 9)
               seg_q.push_back(40);
            else if ($urandom_range(0, 2) == 0)
               seg_q.push_back(edge_lo[$urandom_range(0, 5)]);
            else
               seg_q.push_back(int'($urandom_range(1, 32)));
         end
         build();
         play();
         foreach (obs[j]) begin
            total++;
            if (obs[j] !== exp_ev[j]) begin
               bad++;
               $display("FAIL random_r%0d idx=%0d got=%b exp=%b", round, j, obs[j], exp_ev[j]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_dot();
      test_dot_dash();
      test_letter_h();
      test_len_saturate();
      test_long_press();
      test_gap_boundary();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
